alu_issue_unit: RTL and testbench
=================================

ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and result width.
REQ-002 The block SHALL have parameter SEL_W, default 4, meaning ALU select width.
REQ-003 The block SHALL have parameter SETTLE, default 1, meaning cycles allowed for ALU output to settle; values below 1 SHALL behave as 1.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 Port: clk  input  1  rising-edge clock.
REQ-006 Port: rst  input  1  asynchronous active-high reset.
REQ-007 Port: req_valid  input  1  operation request present.
REQ-008 Port: req_ready  output  1  block can accept a request.
REQ-009 Port: req_a, req_b  input  WIDTH  request operands.
REQ-010 Port: req_sel  input  SEL_W  requested ALU operation.
REQ-011 Port: alu_a, alu_b  output  WIDTH  registered operands to the ALU.
REQ-012 Port: alu_sel  output  SEL_W  registered select to the ALU.
REQ-013 Port: alu_out  input  WIDTH  ALU result.
REQ-014 Port: alu_carry  input  1  ALU carry-out flag.
REQ-015 Port: rsp_valid  output  1  response present.
REQ-016 Port: rsp_ready  input  1  consumer accepts response.
REQ-017 Port: rsp_result  output  WIDTH  captured ALU result.
REQ-018 Port: rsp_carry  output  1  captured carry-out.
REQ-019 Port: rsp_sel  output  SEL_W  select echoed with the response.
REQ-020 Port: op_count  output  16  completed-operation counter.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, SETTLE, RESP.
REQ-022 req_ready SHALL be 1 only in IDLE; it is registered-state-decoded, not dependent on req_valid.
REQ-023 IDLE: on req_valid=1 at a rising edge, the block SHALL load req_a/req_b/req_sel into alu_a/alu_b/alu_sel, load the settle counter with SETTLE, and enter SETTLE.
REQ-024 SETTLE: the counter SHALL decrement once per cycle; on the edge where it reaches 0, the block SHALL capture alu_out, alu_carry, and alu_sel into rsp_result, rsp_carry, and rsp_sel, set rsp_valid, and enter RESP.
REQ-025 Latency: with acceptance at edge N, rsp_valid SHALL first be observed high after edge N+SETTLE.
REQ-026 RESP: rsp_valid and all rsp_* outputs SHALL hold stable until rsp_ready=1 at a rising edge.
REQ-027 On the rsp handshake edge, the block SHALL clear rsp_valid, increment op_count, and enter IDLE; the earliest next acceptance SHALL be one edge later, giving a minimum of SETTLE+2 cycles per operation.
REQ-028 req_valid and operand changes outside IDLE SHALL be ignored, and alu_* outputs SHALL not change.
REQ-029 alu_a/alu_b/alu_sel SHALL retain the last issued values in IDLE; they are not cleared after a response.
REQ-030 rsp_result/rsp_carry/rsp_sel SHALL retain their last values after the handshake; only rsp_valid drops.
REQ-031 op_count SHALL wrap modulo 2^16: 0xFFFF+1 = 0x0000, with no saturation or flag.
REQ-032 The block SHALL perform no arithmetic on the data path; results SHALL be sampled ALU values only.

Reset
REQ-033 While rst=1, the block SHALL immediately force state IDLE, req_ready=1, rsp_valid=0, and alu_a, alu_b, alu_sel, rsp_result, rsp_carry, rsp_sel, op_count, and the settle counter to 0, independent of clk.
REQ-034 Reset asserted in SETTLE or RESP SHALL abort the operation without producing a response or incrementing op_count.
REQ-035 After rst deasserts, the first rising edge with req_valid=1 SHALL be accepted.

Verification
REQ-036 Basic op, with an adder model on sel=0 and SETTLE=1: req a=0x0A, b=0x02, sel=0 -> alu_a=0x0A and alu_b=0x02 after accept; rsp_result=0x0C, rsp_carry=0, op_count=1.
REQ-037 Carry: a=0xFF, b=0x01, sel=0 -> rsp_result=0x00, rsp_carry=1, rsp_sel=0.
REQ-038 Backpressure: hold rsp_ready=0 for 5 cycles in RESP while toggling req_valid/req_a -> rsp_valid stays 1, rsp_result is stable, req_ready=0, and alu_a is unchanged.
REQ-039 Latency, with SETTLE=3: accept at edge N -> rsp_valid is low after N+1 and N+2 and high after N+3; the back-to-back period is 5 cycles.
REQ-040 Reset mid-SETTLE: assert rst asynchronously between edges -> rsp_valid=0, req_ready=1, and all outputs 0 immediately; op_count does not increment.
REQ-041 Wrap: preload 65535 completed operations, then perform one more -> op_count=0x0000.

Source files
------------

// File: rtl/alu_issue_unit.sv
// Issue/capture sequencer for an external combinational ALU: registers one request,
// waits SETTLE cycles for the ALU to settle, then holds the sampled result until consumed.
module alu_issue_unit #(
    parameter int WIDTH  = 8,
    parameter int SEL_W  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [SEL_W-1:0] req_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic [SEL_W-1:0] rsp_sel,
    output logic [15:0]      op_count
);

    // A settle time below one cycle is meaningless; clamp it.
    localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
    localparam int CNT_W      = $clog2(SETTLE_EFF + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_EFF);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic [SEL_W-1:0] rsp_sel_q, rsp_sel_d;
    logic [15:0]      op_count_q, op_count_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_sel_d    = rsp_sel_q;
        op_count_d   = op_count_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    alu_a_d   = req_a;
                    alu_b_d   = req_b;
                    alu_sel_d = req_sel;
                    cnt_d     = SETTLE_LOAD;
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q - CNT_ONE;
                // The edge on which the counter reaches zero is the sampling edge.
                if (cnt_q == CNT_ONE) begin
                    rsp_result_d = alu_out;
                    rsp_carry_d  = alu_carry;
                    rsp_sel_d    = alu_sel_q;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_sel_q    <= '0;
            op_count_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_sel_q    <= rsp_sel_d;
            op_count_q   <= op_count_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = (state_q == ST_RESP);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_sel    = rsp_sel_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit: a SETTLE=1 instance for the data/handshake cases
// and a SETTLE=3 instance for latency, throughput and mid-operation reset.
module tb_alu_issue_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic [7:0] res;
        logic       carry;
    } vec_t;

    vec_t vecs[5];

    // Stand-in ALU: 0 = add, 1 = subtract (carry = borrow), others = xor.
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        case (sel)
            4'd0:    return {1'b0, a} + {1'b0, b};
            4'd1:    return {1'b0, a} - {1'b0, b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    // ---------------- instance with SETTLE=1 ----------------
    logic       s1_req_valid = 1'b0, s1_req_ready, s1_rsp_valid, s1_rsp_ready = 1'b0;
    logic [7:0] s1_req_a = '0, s1_req_b = '0, s1_alu_a, s1_alu_b, s1_alu_out, s1_rsp_result;
    logic [3:0] s1_req_sel = '0, s1_alu_sel, s1_rsp_sel;
    logic       s1_alu_carry, s1_rsp_carry;
    logic [15:0] s1_op_count;
    assign {s1_alu_carry, s1_alu_out} = alu_f(s1_alu_a, s1_alu_b, s1_alu_sel);

    alu_issue_unit #(.WIDTH(8), .SEL_W(4), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(s1_req_valid), .req_ready(s1_req_ready),
        .req_a(s1_req_a), .req_b(s1_req_b), .req_sel(s1_req_sel),
        .alu_a(s1_alu_a), .alu_b(s1_alu_b), .alu_sel(s1_alu_sel),
        .alu_out(s1_alu_out), .alu_carry(s1_alu_carry),
        .rsp_valid(s1_rsp_valid), .rsp_ready(s1_rsp_ready),
        .rsp_result(s1_rsp_result), .rsp_carry(s1_rsp_carry), .rsp_sel(s1_rsp_sel),
        .op_count(s1_op_count)
    );

    // ---------------- instance with SETTLE=3 ----------------
    logic       s3_req_valid = 1'b0, s3_req_ready, s3_rsp_valid, s3_rsp_ready = 1'b0;
    logic [7:0] s3_req_a = '0, s3_req_b = '0, s3_alu_a, s3_alu_b, s3_alu_out, s3_rsp_result;
    logic [3:0] s3_req_sel = '0, s3_alu_sel, s3_rsp_sel;
    logic       s3_alu_carry, s3_rsp_carry;
    logic [15:0] s3_op_count;
    assign {s3_alu_carry, s3_alu_out} = alu_f(s3_alu_a, s3_alu_b, s3_alu_sel);

    alu_issue_unit #(.WIDTH(8), .SEL_W(4), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(s3_req_valid), .req_ready(s3_req_ready),
        .req_a(s3_req_a), .req_b(s3_req_b), .req_sel(s3_req_sel),
        .alu_a(s3_alu_a), .alu_b(s3_alu_b), .alu_sel(s3_alu_sel),
        .alu_out(s3_alu_out), .alu_carry(s3_alu_carry),
        .rsp_valid(s3_rsp_valid), .rsp_ready(s3_rsp_ready),
        .rsp_result(s3_rsp_result), .rsp_carry(s3_rsp_carry), .rsp_sel(s3_rsp_sel),
        .op_count(s3_op_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one request to dut1 and return at the negedge after the accepting edge.
    task automatic s1_issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        @(negedge clk);
        chk("s1_req_ready_before_issue", {31'd0, s1_req_ready}, 32'd1);
        s1_req_valid = 1'b1;
        s1_req_a     = a;
        s1_req_b     = b;
        s1_req_sel   = sel;
        @(posedge clk);
        @(negedge clk);
        s1_req_valid = 1'b0;
        chk("s1_alu_a", {24'd0, s1_alu_a}, {24'd0, a});
        chk("s1_alu_b", {24'd0, s1_alu_b}, {24'd0, b});
        chk("s1_alu_sel", {28'd0, s1_alu_sel}, {28'd0, sel});
    endtask

    task automatic s1_wait_rsp();
        int n = 0;
        while (!s1_rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("s1_rsp_valid_timeout", {31'd0, s1_rsp_valid}, 32'd1);
    endtask

    task automatic s1_consume(input logic [15:0] exp_count);
        s1_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s1_rsp_ready = 1'b0;
        chk("s1_rsp_valid_after_hs", {31'd0, s1_rsp_valid}, 32'd0);
        chk("s1_op_count", {16'd0, s1_op_count}, {16'd0, exp_count});
    endtask

    task automatic s3_wait_rsp();
        int n = 0;
        while (!s3_rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("s3_rsp_valid_timeout", {31'd0, s3_rsp_valid}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{a: 8'h0A, b: 8'h02, sel: 4'd0, res: 8'h0C, carry: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, sel: 4'd0, res: 8'h00, carry: 1'b1};
        vecs[2] = '{a: 8'h80, b: 8'h80, sel: 4'd0, res: 8'h00, carry: 1'b1};
        vecs[3] = '{a: 8'h05, b: 8'h07, sel: 4'd1, res: 8'hFE, carry: 1'b1};
        vecs[4] = '{a: 8'h3C, b: 8'h0F, sel: 4'd2, res: 8'h33, carry: 1'b0};

        // Reset state, with a request pending to show it is ignored during reset.
        s1_req_valid = 1'b1;
        s1_req_a     = 8'h77;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, s1_req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, s1_rsp_valid}, 32'd0);
        chk("rst_alu_a", {24'd0, s1_alu_a}, 32'd0);
        chk("rst_rsp_result", {24'd0, s1_rsp_result}, 32'd0);
        chk("rst_op_count", {16'd0, s1_op_count}, 32'd0);
        s1_req_valid = 1'b0;
        rst = 1'b0;

        // Table-driven operations on dut1.
        for (int i = 0; i < 5; i++) begin
            s1_issue(vecs[i].a, vecs[i].b, vecs[i].sel);
            s1_wait_rsp();
            chk("vec_rsp_result", {24'd0, s1_rsp_result}, {24'd0, vecs[i].res});
            chk("vec_rsp_carry", {31'd0, s1_rsp_carry}, {31'd0, vecs[i].carry});
            chk("vec_rsp_sel", {28'd0, s1_rsp_sel}, {28'd0, vecs[i].sel});
            s1_consume(16'(i + 1));
            chk("vec_result_retained", {24'd0, s1_rsp_result}, {24'd0, vecs[i].res});
            chk("vec_alu_a_retained", {24'd0, s1_alu_a}, {24'd0, vecs[i].a});
        end

        // Backpressure: response held while request inputs wiggle.
        s1_issue(8'h33, 8'h11, 4'd0);
        s1_wait_rsp();
        for (int k = 0; k < 5; k++) begin
            s1_req_valid = ~s1_req_valid;
            s1_req_a     = s1_req_a + 8'h21;
            @(negedge clk);
            chk("bp_rsp_valid", {31'd0, s1_rsp_valid}, 32'd1);
            chk("bp_rsp_result", {24'd0, s1_rsp_result}, 32'h44);
            chk("bp_req_ready", {31'd0, s1_req_ready}, 32'd0);
            chk("bp_alu_a", {24'd0, s1_alu_a}, 32'h33);
        end
        s1_req_valid = 1'b0;
        s1_consume(16'd6);

        // Counter wrap: preload as if 65535 operations had completed.
        @(negedge clk);
        force dut1.op_count_q = 16'hFFFF;
        #1;
        release dut1.op_count_q;
        chk("wrap_preload", {16'd0, s1_op_count}, 32'h0000FFFF);
        s1_issue(8'h01, 8'h02, 4'd0);
        s1_wait_rsp();
        chk("wrap_rsp_result", {24'd0, s1_rsp_result}, 32'h03);
        s1_consume(16'h0000);

        // Latency and back-to-back period on dut3.
        @(negedge clk);
        s3_req_valid = 1'b1;
        s3_req_a     = 8'h10;
        s3_req_b     = 8'h20;
        s3_req_sel   = 4'd0;
        @(posedge clk);
        @(negedge clk);
        s3_req_valid = 1'b0;
        chk("lat_n0_req_ready", {31'd0, s3_req_ready}, 32'd0);
        @(negedge clk);
        chk("lat_n1_rsp_valid", {31'd0, s3_rsp_valid}, 32'd0);
        @(negedge clk);
        chk("lat_n2_rsp_valid", {31'd0, s3_rsp_valid}, 32'd0);
        @(negedge clk);
        chk("lat_n3_rsp_valid", {31'd0, s3_rsp_valid}, 32'd1);
        chk("lat_rsp_result", {24'd0, s3_rsp_result}, 32'h30);
        s3_rsp_ready = 1'b1;
        s3_req_valid = 1'b1;
        s3_req_a     = 8'h01;
        s3_req_b     = 8'h01;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!s3_rsp_valid && n < 20);
            chk("b2b_period", n, 32'd5);
        end
        s3_req_valid = 1'b0;
        @(negedge clk);
        s3_rsp_ready = 1'b0;
        chk("b2b_op_count", {16'd0, s3_op_count}, 32'd2);
        chk("b2b_rsp_result", {24'd0, s3_rsp_result}, 32'h02);

        // Asynchronous reset in the middle of SETTLE.
        @(negedge clk);
        s3_req_valid = 1'b1;
        s3_req_a     = 8'h55;
        s3_req_b     = 8'h11;
        s3_req_sel   = 4'd1;
        @(posedge clk);
        #2;
        s3_req_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_rsp_valid", {31'd0, s3_rsp_valid}, 32'd0);
        chk("mid_rst_req_ready", {31'd0, s3_req_ready}, 32'd1);
        chk("mid_rst_alu_a", {24'd0, s3_alu_a}, 32'd0);
        chk("mid_rst_alu_b", {24'd0, s3_alu_b}, 32'd0);
        chk("mid_rst_alu_sel", {28'd0, s3_alu_sel}, 32'd0);
        chk("mid_rst_rsp_result", {24'd0, s3_rsp_result}, 32'd0);
        chk("mid_rst_rsp_sel", {28'd0, s3_rsp_sel}, 32'd0);
        chk("mid_rst_op_count", {16'd0, s3_op_count}, 32'd0);
        @(negedge clk);
        rst          = 1'b0;
        s3_req_valid = 1'b1;
        s3_req_a     = 8'h21;
        s3_req_b     = 8'h03;
        s3_req_sel   = 4'd0;
        @(posedge clk);
        @(negedge clk);
        s3_req_valid = 1'b0;
        chk("post_rst_accept_alu_a", {24'd0, s3_alu_a}, 32'h21);
        chk("post_rst_op_count", {16'd0, s3_op_count}, 32'd0);
        s3_wait_rsp();
        chk("post_rst_rsp_result", {24'd0, s3_rsp_result}, 32'h24);
        s3_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s3_rsp_ready = 1'b0;
        chk("post_rst_op_count_after", {16'd0, s3_op_count}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
